lsu_ctrl: RTL and testbench

Load/store initiator that sits between the execute stage and the word-wide data memory. It accepts one RV32I load/store request at a time over a valid/ready handshake. It performs byte, halfword and word accesses against the word-only memory port, using read-modify-write for sub-word stores. It returns sign- or zero-extended load data and a store acknowledgement over a response handshake.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_ld_fmt.sv | 28 ++
 rtl/lsu_ctrl.sv | 137 +++++++++++++
 tb/tb_lsu_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 codes, FSM states and the sub-word store merge.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } lsu_state_e;

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [1:0]  off,
    input logic [2:0]  f3
  );
    logic [31:0] w;
    w = old;
    unique case (f3)
      F3_B:    w[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    w[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_ld_fmt.sv
// Load data formatter: picks the addressed byte/halfword
// out of a memory word and sign- or zero-extends it.
module lsu_ld_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{off, 3'b000} +: 8];
    half_v = word[{off[1], 4'b0000} +: 16];
    data   = word;
    unique case (1'b1)
      (funct3 == F3_B):  data = {{24{byte_v[7]}}, byte_v};
      (funct3 == F3_H):  data = {{16{half_v[15]}}, half_v};
      (funct3 == F3_BU): data = {24'd0, byte_v};
      (funct3 == F3_HU): data = {16'd0, half_v};
      default:           data = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between execute and a word-only
// data memory; sub-word stores use read-modify-write.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              dmem_st_en_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_st_data_o,
  input  logic [DATA_W-1:0] dmem_ld_data_i
);

  lsu_state_e state_q, state_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        accept;
  logic        f3_legal;
  logic        misal;
  logic        oor;
  logic        req_err;
  logic [31:0] ld_val;

  assign accept = req_valid_i && (state_q == S_IDLE);

  always_comb begin
    f3_legal = 1'b0;
    unique case (1'b1)
      (req_funct3_i == F3_B),
      (req_funct3_i == F3_H),
      (req_funct3_i == F3_W):  f3_legal = 1'b1;
      (req_funct3_i == F3_BU),
      (req_funct3_i == F3_HU): f3_legal = !req_we_i;
      default:                 f3_legal = 1'b0;
    endcase
  end

  assign misal =
    ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
    ((req_funct3_i[1:0] == 2'b10) &&
     (req_addr_i[1:0] != 2'b00));

  assign oor = (req_addr_i[31:ADDR_W] != '0);

  assign req_err = !f3_legal || misal || oor;

  lsu_ld_fmt u_ld_fmt (
    .word   (dmem_ld_data_i),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_val)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (req_err)
            state_d = S_RESP;
          else if (req_we_i && req_funct3_i == F3_W)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ:  state_d = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i[ADDR_W-1:0];
      wdata_q <= req_wdata_i;
      rdata_q <= '0;
      err_q   <= req_err;
    end else if (state_q == S_READ) begin
      if (we_q) old_q   <= dmem_ld_data_i;
      else      rdata_q <= ld_val;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

  // Reset in the same cycle as WRITE must suppress the store.
  assign dmem_st_en_o = (state_q == S_WRITE) && !rst_i;

  assign dmem_addr_o =
    (state_q == S_READ || state_q == S_WRITE) ?
    {addr_q[ADDR_W-1:2], 2'b00} : '0;

  assign dmem_st_data_o =
    (state_q == S_WRITE) ?
    merge_lanes(old_q, wdata_q, addr_q[1:0], f3_q) : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a byte-level
// reference model of the data memory and RV32I access rules.
module tb_lsu_ctrl;

  localparam int AW = 11;
  localparam int NW = 1 << (AW - 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        st_en;
  logic [AW-1:0] dm_addr;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  logic [31:0] mem [NW];
  logic [31:0] ref_mem [NW];
  logic        poke_en;
  logic [AW-3:0] poke_idx;
  logic [31:0] poke_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_funct3_i   (req_f3),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .dmem_st_en_o   (st_en),
    .dmem_addr_o    (dm_addr),
    .dmem_st_data_o (st_data),
    .dmem_ld_data_i (ld_data)
  );

  assign ld_data = mem[dm_addr[AW-1:2]];

  always @(posedge clk) begin
    if (st_en)
      mem[dm_addr[AW-1:2]] <= st_data;
    else if (poke_en)
      mem[poke_idx] <= poke_data;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_idx  = idx[AW-3:0];
    poke_data = d;
    ref_mem[idx] = d;
    cyc();
    poke_en = 1'b0;
  endtask

  // Access size in bytes, or 0 for an illegal funct3.
  function automatic int acc_size(input logic we,
                                  input logic [2:0] f3);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd4:    return we ? 0 : 1;
      3'd5:    return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_err(input logic we,
                                     input logic [2:0] f3,
                                     input logic [31:0] a);
    int sz;
    sz = acc_size(we, f3);
    if (sz == 0) return 1'b1;
    if (a >= 32'(1 << AW)) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(
    input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = ref_mem[a[AW-1:2]];
    sh = 8 * int'(a % 4);
    case (f3)
      3'd0: begin
        v = (w >> sh) & 32'hFF;
        if (v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      3'd1: begin
        v = (w >> sh) & 32'hFFFF;
        if (v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      3'd4:    v = (w >> sh) & 32'hFF;
      3'd5:    v = (w >> sh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd);
    logic [31:0] w, m;
    int sh;
    w  = ref_mem[a[AW-1:2]];
    sh = 8 * int'(a % 4);
    case (f3)
      3'd0:    m = 32'hFF << sh;
      3'd1:    m = 32'hFFFF << sh;
      default: m = 32'hFFFF_FFFF;
    endcase
    return (w & ~m) | ((wd << sh) & m);
  endfunction

  task automatic do_req(input logic we,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int stall);
    logic        e;
    logic [31:0] exp_rd, exp_w, sd, rd0;
    int          exp_lat, lat, pulses, idx;
    idx    = int'(a[AW-1:2]);
    e      = model_err(we, f3, a);
    exp_rd = (!we && !e) ? model_load(f3, a) : 32'd0;
    exp_w  = (we && !e) ? model_store(f3, a, wd)
                        : ref_mem[idx];
    exp_lat = e ? 1 : (we && f3 != 3'd2) ? 3 : 2;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = a;
    req_wdata = wd;
    cyc();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    chk("first_addr", 32'(dm_addr),
        e ? 32'd0 : {a[31:2], 2'b00});
    lat = 0; pulses = 0; sd = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      if (st_en) begin
        pulses++;
        sd = st_data;
        chk("st_addr", 32'(dm_addr), {a[31:2], 2'b00});
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
      cyc();
    end
    chk("latency", lat, exp_lat);
    chk("rsp_err", 32'(rsp_err), 32'(e));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("st_pulses", pulses, (we && !e) ? 1 : 0);
    if (we && !e) chk("st_data", sd, exp_w);
    rd0 = rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      cyc();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, rd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_st_en", 32'(st_en), 32'd0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    ref_mem[idx] = exp_w;
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_st_en"}, 32'(st_en), 32'd0);
    chk({tag, "_addr"}, 32'(dm_addr), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_stdata"}, st_data, 32'd0);
  endtask

  logic [2:0]  rf3;
  logic [31:0] ra;
  logic        rwe;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    rsp_ready = 1'b0;
    poke_en = 1'b0; poke_idx = '0; poke_data = 32'd0;
    cyc();
    cyc();
    chk_reset_outs("reset");
    for (int i = 0; i < NW; i++) poke(i, $urandom);
    rst = 1'b0;
    cyc();
    chk_reset_outs("idle");

    poke(4, 32'h8000_00FF);
    poke(8, 32'h1122_3344);
    do_req(1'b0, 3'd2, 32'h10, 32'd0, 0);
    do_req(1'b0, 3'd0, 32'h10, 32'd0, 0);
    do_req(1'b0, 3'd4, 32'h13, 32'd0, 0);
    do_req(1'b0, 3'd1, 32'h12, 32'd0, 0);
    do_req(1'b1, 3'd0, 32'h21, 32'hFFFF_FFAA, 0);
    do_req(1'b1, 3'd1, 32'h22, 32'h1234_BEEF, 0);
    chk("sh_word", mem[8], 32'hBEEF_AA44);

    do_req(1'b0, 3'd2, 32'h06, 32'd0, 0);
    do_req(1'b1, 3'd1, 32'h03, 32'h5555, 0);
    do_req(1'b0, 3'd2, 32'h800, 32'd0, 0);
    do_req(1'b0, 3'd3, 32'h40, 32'd0, 0);
    do_req(1'b1, 3'd4, 32'h40, 32'h77, 1);
    do_req(1'b0, 3'd5, 32'h8000_0002, 32'd0, 0);
    do_req(1'b0, 3'd2, 32'h10, 32'd0, 5);

    // Reset while an SB is in READ.
    poke(12, 32'hCAFE_F00D);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd0;
    req_addr = 32'h31; req_wdata = 32'h99;
    cyc();
    req_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset_outs("rst_read");
    cyc();
    chk("rst_read_mem", mem[12], ref_mem[12]);

    // Reset landing on the WRITE cycle of an SH.
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd1;
    req_addr = 32'h32; req_wdata = 32'h4321;
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("pre_rst_st_en", 32'(st_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_write_st_en", 32'(st_en), 32'd0);
    cyc();
    rst = 1'b0;
    chk_reset_outs("rst_write");
    chk("rst_write_mem", mem[12], ref_mem[12]);

    for (int n = 0; n < 120; n++) begin
      rwe = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rf3 = 3'($urandom);
      else if (rwe) rf3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: rf3 = 3'd0;
          1: rf3 = 3'd1;
          2: rf3 = 3'd2;
          3: rf3 = 3'd4;
          default: rf3 = 3'd5;
        endcase
      end
      case ($urandom_range(0, 9))
        0: ra = $urandom;
        1: ra = 32'($urandom_range(0, 2047));
        default: begin
          ra = 32'($urandom_range(0, 2047));
          if (acc_size(rwe, rf3) != 0)
            ra = ra - (ra % 32'(acc_size(rwe, rf3)));
        end
      endcase
      do_req(rwe, rf3, ra, $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
